// File: rtl/dds_param_pkg.sv
// Shared types and constants for the DDS parameter sequencer.
// The GET_CK state exists only when DDS_CKSUM_EN is defined.
package dds_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_HI = 3'd1,
        ST_GET_LO = 3'd2,
        ST_CONV   = 3'd3,
        ST_COMMIT = 3'd4
`ifdef DDS_CKSUM_EN
        , ST_GET_CK = 3'd5
`endif
    } state_t;

    localparam logic [1:0] ADDR_FREQ      = 2'd0;
    localparam logic [1:0] ADDR_PHASE     = 2'd1;
    localparam logic [1:0] ADDR_AMP       = 2'd2;
    localparam int         CMD_COMMIT_BIT = 7;
    localparam logic [7:0] AMP_SAT        = 8'hFF;

endpackage

// File: rtl/amp_scale_div.sv
// Amplitude scaler: (din * AMP_NUM) / AMP_DEN by restoring division, one
// quotient bit per cycle, result saturated to 8 bits.
module amp_scale_div
    import dds_param_pkg::*;
#(
    parameter int AMP_NUM = 25,
    parameter int AMP_DEN = 100,
    parameter int DIV_CYC = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic [15:0] din,
    output logic        done,
    output logic [7:0]  dout
);

    localparam int CW = $clog2(DIV_CYC + 1);

    logic [DIV_CYC-1:0] dvd, dvd_d, prod;
    logic [7:0]         rem, rem_d;
    logic [8:0]         rem_sh;
    logic [CW-1:0]      cnt;
    logic               run, ge;

    assign prod   = DIV_CYC'(din) * DIV_CYC'(AMP_NUM);
    assign rem_sh = {rem, dvd[DIV_CYC-1]};
    assign ge     = rem_sh >= 9'(AMP_DEN);
    // remainder stays below AMP_DEN, so it always fits back into 8 bits
    assign rem_d  = ge ? 8'(rem_sh - 9'(AMP_DEN)) : rem_sh[7:0];
    assign dvd_d  = {dvd[DIV_CYC-2:0], ge};

    // done is raised during the last iteration so the caller can capture the
    // final quotient on the same edge that completes it
    assign done = run && (cnt == CW'(1));
    assign dout = (|dvd_d[DIV_CYC-1:8]) ? AMP_SAT : dvd_d[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            dvd <= '0;
            rem <= '0;
        end else if (clear) begin
            run <= 1'b0;
            cnt <= '0;
            dvd <= '0;
            rem <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(DIV_CYC);
            dvd <= prod;
            rem <= '0;
        end else if (run) begin
            dvd <= dvd_d;
            rem <= rem_d;
            cnt <= cnt - CW'(1);
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_param_ctrl.sv
// SPI byte-stream to DDS parameter sequencer with atomic commit.
// Define DDS_CKSUM_EN to require a 4th XOR checksum byte per frame.
module dds_param_ctrl
    import dds_param_pkg::*;
#(
    parameter int AMP_NUM = 25,
    parameter int AMP_DEN = 100,
    parameter int DIV_CYC = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        frame_abort,
    output logic [15:0] freq_word,
    output logic [15:0] phase_word,
    output logic [7:0]  amp_word,
    output logic        param_upd,
    output logic        busy,
    output logic        err_cmd
);

    state_t      state;
    logic        ready_en, commit_q, xfer, frame_end, ck_ok;
    logic        div_start, div_done;
    logic [1:0]  addr_q;
    logic [7:0]  hi_q, div_out, amp_sh;
    logic [15:0] frame_data, freq_sh, phase_sh;

    // ready_en keeps rx_ready low while reset is asserted
    assign xfer = rx_valid && rx_ready && !frame_abort;
    assign busy = (state == ST_CONV) || (state == ST_COMMIT);

`ifdef DDS_CKSUM_EN
    logic [7:0] lo_q, ck_acc;

    assign frame_data = {hi_q, lo_q};
    assign ck_ok      = (rx_data == ck_acc);
    assign frame_end  = xfer && (state == ST_GET_CK);
    assign rx_ready   = ready_en &&
                        (state inside {ST_IDLE, ST_GET_HI, ST_GET_LO, ST_GET_CK});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ck_acc <= '0;
        else if (xfer) ck_acc <= (state == ST_IDLE) ? rx_data : (ck_acc ^ rx_data);
    end
`else
    assign frame_data = {hi_q, rx_data};
    assign ck_ok      = 1'b1;
    assign frame_end  = xfer && (state == ST_GET_LO);
    assign rx_ready   = ready_en && (state inside {ST_IDLE, ST_GET_HI, ST_GET_LO});
`endif

    assign div_start = frame_end && ck_ok && (addr_q == ADDR_AMP);

    amp_scale_div #(
        .AMP_NUM (AMP_NUM),
        .AMP_DEN (AMP_DEN),
        .DIV_CYC (DIV_CYC)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .clear (frame_abort),
        .din   (frame_data),
        .done  (div_done),
        .dout  (div_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ready_en   <= 1'b0;
            addr_q     <= '0;
            commit_q   <= 1'b0;
            hi_q       <= '0;
`ifdef DDS_CKSUM_EN
            lo_q       <= '0;
`endif
            freq_sh    <= '0;
            phase_sh   <= '0;
            amp_sh     <= '0;
            freq_word  <= '0;
            phase_word <= '0;
            amp_word   <= '0;
            param_upd  <= 1'b0;
            err_cmd    <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            err_cmd   <= 1'b0;
            param_upd <= 1'b0;

            // COMMIT is a single cycle, so it completes even under abort
            if (state == ST_COMMIT) begin
                freq_word  <= freq_sh;
                phase_word <= phase_sh;
                amp_word   <= amp_sh;
                param_upd  <= 1'b1;
            end

            if (frame_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (xfer) begin
                        addr_q   <= rx_data[1:0];
                        commit_q <= rx_data[CMD_COMMIT_BIT];
                        state    <= ST_GET_HI;
                    end
                    ST_GET_HI: if (xfer) begin
                        hi_q  <= rx_data;
                        state <= ST_GET_LO;
                    end
`ifdef DDS_CKSUM_EN
                    ST_GET_LO: if (xfer) begin
                        lo_q  <= rx_data;
                        state <= ST_GET_CK;
                    end
                    ST_GET_CK: ;
`else
                    ST_GET_LO: ;
`endif
                    ST_CONV: if (div_done) begin
                        amp_sh <= div_out;
                        state  <= commit_q ? ST_COMMIT : ST_IDLE;
                    end
                    ST_COMMIT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase

                // last byte of the frame: dispatch on the address
                if (frame_end) begin
                    state <= ST_IDLE;
                    if (!ck_ok || addr_q == 2'd3) begin
                        err_cmd <= 1'b1;
                    end else if (addr_q == ADDR_AMP) begin
                        state <= ST_CONV;
                    end else begin
                        if (addr_q == ADDR_FREQ)  freq_sh  <= frame_data;
                        if (addr_q == ADDR_PHASE) phase_sh <= frame_data;
                        if (commit_q)             state    <= ST_COMMIT;
                    end
                end
            end
        end
    end

endmodule
